// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding imem read, results buffered in a DEPTH-entry FIFO.
// Latency: accept at N, request at N+1, INST_VALID at N+2 for an ack at N+1; FLUSH/ERR handled inline.
module fetch_queue #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] BASE  = 32'h00400000,
    parameter int          AW    = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [31:0]   pc_in_i,
    input  logic          pc_valid_i,
    output logic          pc_ready_o,
    output logic          imem_req_o,
    output logic [AW-1:0] imem_addr_o,
    input  logic          imem_ack_i,
    input  logic [31:0]   imem_data_i,
    output logic [31:0]   inst_out_o,
    output logic [31:0]   inst_pc_o,
    output logic          inst_valid_o,
    input  logic          inst_ready_i,
    input  logic          flush_i,
    output logic          err_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            req_q, req_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     pend_pc_q, pend_pc_d;
    logic            err_q, err_d;
    logic [31:0]     inst_mem_q [DEPTH];
    logic [31:0]     pc_mem_q   [DEPTH];

    logic [31:0]     offset;
    logic            legal;
    logic            accept;
    logic            push;
    logic            pop;

    // Word index must fit in AW bits: every offset bit above AW+1 has to be zero.
    assign offset     = pc_in_i - BASE;
    assign legal      = (pc_in_i[1:0] == 2'b00) && (pc_in_i >= BASE) &&
                        ((offset >> (AW + 2)) == 32'd0);
    assign pc_ready_o = (state_q == S_IDLE) && (count_q < CW'(DEPTH)) && !flush_i && !rst_i;
    assign accept     = pc_valid_i && pc_ready_o;

    assign inst_valid_o = (count_q != '0);
    assign pop          = inst_valid_o && inst_ready_i && !flush_i;
    assign inst_out_o   = inst_valid_o ? inst_mem_q[rd_ptr_q] : 32'd0;
    assign inst_pc_o    = inst_valid_o ? pc_mem_q[rd_ptr_q]   : 32'd0;
    assign imem_req_o   = req_q;
    assign imem_addr_o  = addr_q;
    assign err_o        = err_q;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        pend_pc_d = pend_pc_q;
        err_d     = err_q;
        push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (legal) begin
                        state_d   = S_WAIT;
                        req_d     = 1'b1;
                        addr_d    = offset[AW+1:2];
                        pend_pc_d = pc_in_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (imem_ack_i) begin
                    push    = !flush_i;
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (flush_i) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // A slot was reserved when the fetch was accepted, so push never sees a full queue.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            pend_pc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            pend_pc_q <= pend_pc_d;
            err_q     <= err_d;
        end
    end

    // Storage is not reset; the outputs are gated by INST_VALID instead.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            inst_mem_q[wr_ptr_q] <= imem_data_i;
            pc_mem_q[wr_ptr_q]   <= pend_pc_q;
        end
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set queue entries; power of two, at least 2.
REQ-002 Parameter BASE, default 32'h00400000, SHALL set the byte address mapped to instruction-memory word 0.
REQ-003 Parameter AW, default 11, SHALL set the instruction-memory word-index width.
REQ-004 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RST  in  1  SHALL be the synchronous, active-high reset.
REQ-006 PC_IN  in  32  SHALL carry the byte address to fetch.
REQ-007 PC_VALID  in  1  SHALL mark PC_IN as a fetch request.
REQ-008 PC_READY  out  1  SHALL indicate the block accepts a fetch this cycle.
REQ-009 IMEM_REQ  out  1  SHALL carry the registered memory read request.
REQ-010 IMEM_ADDR  out  AW  SHALL carry the registered word index.
REQ-011 IMEM_ACK  in  1  SHALL mark IMEM_DATA valid for the pending request.
REQ-012 IMEM_DATA  in  32  SHALL carry the instruction word returned by memory.
REQ-013 INST_OUT  out  32  SHALL carry the queue-head instruction.
REQ-014 INST_PC  out  32  SHALL carry the byte address of INST_OUT.
REQ-015 INST_VALID  out  1  SHALL indicate the queue is non-empty.
REQ-016 INST_READY  in  1  SHALL let the consumer pop the head.
REQ-017 FLUSH  in  1  SHALL discard all queued and in-flight fetches (branch redirect).
REQ-018 ERR  out  1  SHALL be a sticky flag for a rejected fetch address.

Function
REQ-019 FSM states SHALL be IDLE, WAIT, DROP; one request outstanding at most.
REQ-020 PC_READY SHALL equal (state==IDLE) && count<DEPTH && !FLUSH && !RST.
REQ-021 Accept (PC_VALID && PC_READY): a legal address SHALL register IMEM_REQ=1 and IMEM_ADDR=(PC_IN-BASE)>>2, and the block SHALL enter WAIT.
REQ-022 An address is illegal if PC_IN[1:0]!=0, PC_IN<BASE, or (PC_IN-BASE)>>2 >= 2^AW; an illegal address SHALL issue no request, SHALL set ERR, and the block SHALL stay in IDLE.
REQ-023 In WAIT, IMEM_REQ and IMEM_ADDR SHALL hold until IMEM_ACK=1.
REQ-024 On that cycle {IMEM_DATA, address} SHALL be pushed, IMEM_REQ SHALL drop, and the block SHALL enter IDLE.
REQ-025 Latency: accept at cycle N, IMEM_REQ high at N+1, ACK at N+1 at the earliest; INST_VALID SHALL be high at N+2 with an empty queue.
REQ-026 A slot SHALL be reserved at accept, so a push SHALL never occur when full.
REQ-027 Pop SHALL occur when INST_VALID && INST_READY; simultaneous push and pop SHALL leave count unchanged.
REQ-028 Pointers SHALL wrap modulo DEPTH.
REQ-029 INST_OUT and INST_PC SHALL be 0 when INST_VALID=0.
REQ-030 On FLUSH, count and pointers SHALL clear next cycle; FLUSH SHALL win over a simultaneous pop or push.
REQ-031 FLUSH in WAIT without ACK SHALL enter DROP; FLUSH in WAIT with ACK SHALL discard the data and enter IDLE.
REQ-032 DROP SHALL hold IMEM_REQ until ACK, discard the data, then enter IDLE; FLUSH in DROP SHALL keep DROP.
REQ-033 IMEM_ACK in IDLE SHALL be ignored.
REQ-034 ERR SHALL be cleared only by RST.

Reset
REQ-035 While RST=1 at a rising edge, state SHALL become IDLE, count and pointers 0, and IMEM_REQ, IMEM_ADDR, INST_VALID, INST_OUT, INST_PC and ERR 0.
REQ-036 Reset in WAIT or DROP SHALL abandon the request; a late ACK SHALL be ignored.

Verification
REQ-037 Fetch 32'h00400008, ACK one cycle later with 32'h8C010004 -> IMEM_ADDR=2; INST_OUT=32'h8C010004, INST_PC=32'h00400008, INST_VALID at N+2.
REQ-038 Four fetches, INST_READY=0 -> count=4, PC_READY=0; one pop -> PC_READY=1; pop order matches fetch order.
REQ-039 PC_IN=32'h00400002, then 32'h003FFFFC -> no IMEM_REQ; ERR=1 until RST.
REQ-040 FLUSH in WAIT, ACK two cycles later -> state DROP, data discarded, INST_VALID stays 0, IDLE after ACK.
REQ-041 Push and pop in the same cycle at count=2 -> count stays 2; head advances.
REQ-042 RST during WAIT, then ACK -> all outputs 0, no push, PC_READY=1 after RST drops.
